// File: rtl/traffic_pkg.sv
// Shared types, lamp bit positions and the round-robin helper for the traffic controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } phase_t;

    localparam int LAMP_R = 2;
    localparam int LAMP_Y = 1;
    localparam int LAMP_G = 0;

    localparam int MAX_WAYS = 8;
    localparam int WAY_W    = 3;

    // Wrap scan from active+1; returns active itself when no other way is requesting.
    function automatic logic [WAY_W-1:0] rr_next(
        input logic [WAY_W-1:0]    active,
        input logic [MAX_WAYS-1:0] req,
        input int unsigned         n_ways = MAX_WAYS
    );
        logic [WAY_W-1:0] idx;
        logic             found;
        int unsigned      sum;
        rr_next = active;
        found   = 1'b0;
        for (int unsigned i = 1; i < MAX_WAYS; i++) begin
            if (!found && i < n_ways) begin
                sum = int'(active) + i;
                idx = WAY_W'(sum % n_ways);
                if (req[idx]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clk cycles.
module tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multi_way_traffic_fsm.sv
// N-way round-robin traffic light controller with tick-based green/yellow/all-red timing.
// Optional green extension while the active way keeps demand: define TLC_EXTEND_EN.
module multi_way_traffic_fsm
    import traffic_pkg::*;
#(
    parameter int N_WAYS    = 2,
    parameter int TICK_DIV  = 1,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_WAYS-1:0]         sensor,
    output logic [3*N_WAYS-1:0]       led,
    output logic [$clog2(N_WAYS)-1:0] active_way,
    output logic [1:0]                phase
);

    localparam int AW = $clog2(N_WAYS);
`ifdef TLC_EXTEND_EN
    localparam int GREEN_LIM = GREEN_MAX;
`else
    localparam int GREEN_LIM = GREEN_MIN;
`endif
    localparam int T_MAX_GY = (GREEN_LIM > YELLOW_T) ? GREEN_LIM : YELLOW_T;
    localparam int T_MAX    = (T_MAX_GY > ALLRED_T) ? T_MAX_GY : ALLRED_T;
    localparam int TW       = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] GMIN_M1  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GLIM_M1  = TW'(GREEN_LIM - 1);
    localparam logic [TW-1:0] YEL_M1   = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRD_M1 = TW'(ALLRED_T - 1);

    if (N_WAYS < 2 || N_WAYS > MAX_WAYS || TICK_DIV < 1 || GREEN_MIN < 1 ||
        GREEN_MAX < GREEN_MIN || YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_cfg
        $error("multi_way_traffic_fsm: illegal parameter set");
    end

    phase_t          phase_q, phase_d;
    logic [AW-1:0]   active_q, active_d;
    logic [AW-1:0]   next_q, next_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            tick;
    logic            other_demand;
    logic            leave_green;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        phase_d      = phase_q;
        active_d     = active_q;
        next_d       = next_q;
        timer_d      = timer_q;
        other_demand = |(sensor & ~(N_WAYS'(1) << active_q));
        leave_green  = (timer_q >= GMIN_M1) && other_demand;
`ifdef TLC_EXTEND_EN
        leave_green  = leave_green && (!sensor[active_q] || timer_q >= GLIM_M1);
`endif

        if (tick) begin
            unique case (phase_q)
                GREEN: begin
                    if (leave_green) begin
                        phase_d = YELLOW;
                        timer_d = '0;
                        next_d  = AW'(rr_next(WAY_W'(active_q), MAX_WAYS'(sensor), N_WAYS));
                    end else if (timer_q < GLIM_M1) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                YELLOW: begin
                    if (timer_q == YEL_M1) begin
                        phase_d = ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ALLRED: begin
                    if (timer_q == ALLRD_M1) begin
                        phase_d  = GREEN;
                        active_d = next_q;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    phase_d = GREEN;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q  <= GREEN;
            active_q <= '0;
            next_q   <= '0;
            timer_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            next_q   <= next_d;
            timer_q  <= timer_d;
        end
    end

    // Lamps are a pure decode of registered state, so reset reaches them without a clock.
    always_comb begin
        led = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (phase_q == GREEN && AW'(i) == active_q)       led[3*i + LAMP_G] = 1'b1;
            else if (phase_q == YELLOW && AW'(i) == active_q) led[3*i + LAMP_Y] = 1'b1;
            else                                              led[3*i + LAMP_R] = 1'b1;
        end
    end

    assign active_way = active_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_multi_way_traffic_fsm.sv
// Self-checking bench: cycle-count reference model compared every cycle plus directed literal checks.
module tb_multi_way_traffic_fsm;

    localparam int N    = 3;
    localparam int TD   = 1;
    localparam int GMIN = 4;
    localparam int GMAX = 8;
    localparam int YT   = 2;
    localparam int AR   = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] sensor = 3'b000;
    logic [8:0] led;
    logic [1:0] active_way;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_way_traffic_fsm #(
        .N_WAYS    (N),
        .TICK_DIV  (TD),
        .GREEN_MIN (GMIN),
        .GREEN_MAX (GMAX),
        .YELLOW_T  (YT),
        .ALLRED_T  (AR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sensor     (sensor),
        .led        (led),
        .active_way (active_way),
        .phase      (phase)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: phase 0=green 1=yellow 2=all-red, counted in whole cycles spent in the phase.
    int m_phase = 0;
    int m_way   = 0;
    int m_next  = 0;
    int m_cyc   = 0;
    int m_n;
    bit m_other;
    bit m_own;
    bit m_leave;

    function automatic int pick_next(input int from, input logic [2:0] s);
        for (int k = 1; k < N; k++) begin
            if (s[(from + k) % N]) return (from + k) % N;
        end
        return from;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_way = 0; m_next = 0; m_cyc = 0;
        end else begin
            m_n     = m_cyc + 1;
            m_other = 1'b0;
            for (int w = 0; w < N; w++) if (w != m_way && sensor[w]) m_other = 1'b1;
            m_own = sensor[m_way];
            case (m_phase)
                0: begin
                    m_leave = (m_n >= GMIN) && m_other;
`ifdef TLC_EXTEND_EN
                    m_leave = m_leave && (!m_own || m_n >= GMAX);
`endif
                    if (m_leave) begin
                        m_phase = 1; m_next = pick_next(m_way, sensor); m_cyc = 0;
                    end else m_cyc = m_n;
                end
                1: if (m_n == YT) begin m_phase = 2; m_cyc = 0; end else m_cyc = m_n;
                default: if (m_n == AR) begin m_phase = 0; m_way = m_next; m_cyc = 0; end else m_cyc = m_n;
            endcase
        end
    end

    function automatic logic [8:0] exp_led();
        logic [8:0] l;
        for (int w = 0; w < N; w++) begin
            if (m_phase == 2 || w != m_way) l[3*w +: 3] = 3'b100;
            else if (m_phase == 0)          l[3*w +: 3] = 3'b001;
            else                            l[3*w +: 3] = 3'b010;
        end
        return l;
    endfunction

    always @(negedge clk) begin
        check("model_led",   32'(led),        32'(exp_led()));
        check("model_phase", 32'(phase),      32'(m_phase));
        check("model_way",   32'(active_way), 32'(m_way));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [2:0] s);
        step(1);
        reset_n = 1'b0;
        sensor  = s;
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        // 1: idle, no demand
        do_reset(3'b000);
        step(50);
        check("idle_led",   32'(led),        32'(9'b100_100_001));
        check("idle_phase", 32'(phase),      32'd0);
        check("idle_way",   32'(active_way), 32'd0);

        // 2: only way 2 requests, way 1 skipped
        do_reset(3'b100);
        step(3);
        check("skip_green_end", 32'(led), 32'(9'b100_100_001));
        step(1);
        check("skip_yellow",    32'(led), 32'(9'b100_100_010));
        step(2);
        check("skip_allred",    32'(led), 32'(9'b100_100_100));
        step(1);
        check("skip_way2_led",  32'(led),        32'(9'b001_100_100));
        check("skip_way2_idx",  32'(active_way), 32'd2);

        // 3: all request, round-robin 0,1,2,0 with 7-cycle period
        do_reset(3'b111);
        step(7);
        check("rr_way1",       32'(active_way), 32'd1);
        check("rr_way1_green", 32'(phase),      32'd0);
        step(3);
        check("rr_way1_last_green", 32'(phase), 32'd0);
        step(1);
        check("rr_way1_yellow", 32'(phase), 32'd1);
        step(3);
        check("rr_way2", 32'(active_way), 32'd2);
        step(7);
        check("rr_way0_again", 32'(active_way), 32'd0);
        check("rr_way0_led",   32'(led),        32'(9'b100_100_001));

        // 4: only the active way requests
        do_reset(3'b001);
        step(100);
        check("own_only_led", 32'(led), 32'(9'b100_100_001));

        // 5: async reset during the second yellow cycle
        do_reset(3'b010);
        step(5);
        check("pre_reset_yellow", 32'(phase), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_led",   32'(led),   32'(9'b100_100_001));
        check("async_reset_phase", 32'(phase), 32'd0);

`ifdef TLC_EXTEND_EN
        // 6: extension to GREEN_MAX, then early exit when own demand drops
        do_reset(3'b011);
        step(7);
        check("ext_still_green", 32'(phase), 32'd0);
        step(1);
        check("ext_max_yellow",  32'(led),   32'(9'b100_100_010));
        do_reset(3'b011);
        step(5);
        check("ext_drop_green", 32'(phase), 32'd0);
        sensor = 3'b010;
        step(1);
        check("ext_drop_yellow", 32'(phase), 32'd1);
`else
        // 6: without extension, own demand does not stretch green
        do_reset(3'b011);
        step(3);
        check("noext_green",  32'(phase), 32'd0);
        step(1);
        check("noext_yellow", 32'(phase), 32'd1);
        step(3);
        check("noext_way1", 32'(active_way), 32'd1);
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
